spi_read_master: RTL and testbench

//  SPI initiator that performs one register read against an address-matched SPI read

---
 rtl/spi_read_master_if.sv | 26 ++
 rtl/spi_read_master.sv | 179 +++++++++++++++++
 tb/tb_spi_read_master.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_read_master_if.sv
// Handshake and SPI pin bundle for spi_read_master.
// The master modport is the initiator's view; slave is the counterpart (controller + SPI slave).
interface spi_read_master_if #(
  parameter int Nbit = 32,
  parameter int Abit = 8
);
  logic            start;
  logic [Abit-1:0] adr;
  logic            busy;
  logic [Nbit-1:0] dout;
  logic            valid;
  logic            cs;
  logic            sclk;
  logic            mosi;
  logic            miso;

  modport master (
    input  start, adr, miso,
    output busy, dout, valid, cs, sclk, mosi
  );

  modport slave (
    output start, adr, miso,
    input  busy, dout, valid, cs, sclk, mosi
  );
endinterface

// File: rtl/spi_read_master.sv
// SPI read initiator: drops cs, shifts an address out MSB-first, then clocks a data
// word in on miso and presents it with a one-cycle valid pulse. All outputs registered.
module spi_read_master #(
  parameter int Nbit     = 32,
  parameter int Abit     = 8,
  parameter int Dlitl    = 5,
  parameter int CS_SETUP = 10,
  parameter int CS_HOLD  = 10,
  parameter int CS_IDLE  = 10
) (
  input logic               clk,
  input logic               rst,
  spi_read_master_if.master bus
);
  localparam int BMAX = (Abit > Nbit) ? Abit : Nbit;
  localparam int BW   = $clog2(BMAX + 1);
  localparam int HW   = $clog2(Dlitl + 1);
  localparam int CMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                             : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [HW-1:0] HALF_LAST  = HW'(Dlitl - 1);
  localparam logic [BW-1:0] ADDR_LAST  = BW'(Abit - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(Nbit - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  // FIN already provides one cs-high cycle, and busy drops in the last CSIDLE cycle
  localparam logic [CW-1:0] IDLE_LAST  = CW'((CS_IDLE >= 2) ? CS_IDLE - 2 : 0);

  typedef enum logic [2:0] {IDLE, SETUP, ADDR, GAP, DATA, HOLD, FIN, CSIDLE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [HW-1:0]   hcnt_reg, hcnt_next;
  logic            ph_reg, ph_next;
  logic [BW-1:0]   bcnt_reg, bcnt_next;
  logic [Abit-1:0] addr_sh_reg, addr_sh_next;
  logic [Nbit-1:0] data_sh_reg, data_sh_next;
  logic [Nbit-1:0] dout_reg, dout_next;
  logic            cs_reg, cs_next;
  logic            sclk_reg, sclk_next;
  logic            mosi_reg, mosi_next;
  logic            busy_reg, busy_next;
  logic            valid_reg, valid_next;
  logic            half_end, slot_end;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hcnt_next    = hcnt_reg;
    ph_next      = ph_reg;
    bcnt_next    = bcnt_reg;
    addr_sh_next = addr_sh_reg;
    data_sh_next = data_sh_reg;
    dout_next    = dout_reg;
    half_end     = (hcnt_reg == HALF_LAST);
    slot_end     = half_end && ph_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start && !busy_reg) begin
          state_next   = SETUP;
          cnt_next     = '0;
          addr_sh_next = bus.adr;
        end
      end
      SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          state_next = ADDR;
          hcnt_next  = '0;
          ph_next    = 1'b0;
          bcnt_next  = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ADDR, DATA: begin
        if (half_end) begin
          hcnt_next = '0;
          ph_next   = ~ph_reg;
        end else begin
          hcnt_next = hcnt_reg + 1'b1;
        end
        // miso is taken in the last sclk-high cycle; the address advances at slot end
        if (slot_end) begin
          if (state_reg == ADDR) begin
            addr_sh_next = addr_sh_reg << 1;
            if (bcnt_reg == ADDR_LAST) state_next = GAP;
            else                       bcnt_next  = bcnt_reg + 1'b1;
          end else begin
            data_sh_next = {data_sh_reg[Nbit-2:0], bus.miso};
            if (bcnt_reg == DATA_LAST) begin
              state_next = HOLD;
              cnt_next   = '0;
            end else begin
              bcnt_next = bcnt_reg + 1'b1;
            end
          end
        end
      end
      GAP: begin
        state_next = DATA;
        hcnt_next  = '0;
        ph_next    = 1'b0;
        bcnt_next  = '0;
      end
      HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = FIN;
          dout_next  = data_sh_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FIN: begin
        cnt_next   = '0;
        state_next = (CS_IDLE >= 2) ? CSIDLE : IDLE;
      end
      CSIDLE: begin
        if (bus.start && !busy_reg) begin
          state_next   = SETUP;
          cnt_next     = '0;
          addr_sh_next = bus.adr;
        end else if (cnt_reg == IDLE_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    cs_next    = !(state_next inside {SETUP, ADDR, GAP, DATA, HOLD});
    sclk_next  = ((state_next == ADDR) || (state_next == DATA)) && ph_next;
    mosi_next  = (state_next == ADDR) ? addr_sh_next[Abit-1] : 1'b1;
    valid_next = (state_next == FIN);
    busy_next  = !((state_next == IDLE) ||
                   ((state_next == CSIDLE) && (cnt_next == IDLE_LAST)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      hcnt_reg    <= '0;
      ph_reg      <= 1'b0;
      bcnt_reg    <= '0;
      addr_sh_reg <= '0;
      data_sh_reg <= '0;
      dout_reg    <= '0;
      cs_reg      <= 1'b1;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b1;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hcnt_reg    <= hcnt_next;
      ph_reg      <= ph_next;
      bcnt_reg    <= bcnt_next;
      addr_sh_reg <= addr_sh_next;
      data_sh_reg <= data_sh_next;
      dout_reg    <= dout_next;
      cs_reg      <= cs_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      busy_reg    <= busy_next;
      valid_reg   <= valid_next;
    end
  end

  assign bus.cs    = cs_reg;
  assign bus.sclk  = sclk_reg;
  assign bus.mosi  = mosi_reg;
  assign bus.busy  = busy_reg;
  assign bus.valid = valid_reg;
  assign bus.dout  = dout_reg;
endmodule

// File: tb/tb_spi_read_master.sv
// Bench for spi_read_master: a behavioural SPI slave answers reads from a memory model,
// and each scenario task compares latency, data and pin timing against expected values.
module tb_spi_read_master;
  localparam int NB  = 32;
  localparam int AB  = 8;
  localparam int DL  = 5;
  localparam int CSS = 10;
  localparam int CSH = 10;
  localparam int CSI = 10;
  localparam int T   = CSS + 2*DL*(AB+NB) + CSH + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [NB-1:0] mem [256];

  spi_read_master_if #(.Nbit(NB), .Abit(AB)) bus();

  spi_read_master #(
    .Nbit(NB), .Abit(AB), .Dlitl(DL), .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_IDLE(CSI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NB-1:0] slave_word(input logic [AB-1:0] a);
    if (a == 8'd1)      return 32'hDEEDBEEF;
    else if (a == 8'd3) return '1;
    else                return mem[a];
  endfunction

  // slave + pin monitor, sampled on the falling clk edge
  logic          prev_cs = 1'b1;
  logic          prev_sclk = 1'b0;
  int            rise_cnt, fall_cnt, cs_low_cnt, hi_run, lo_run, hi_bad, lo_n, lo_gap;
  int            cs_hi_run = 0, last_cs_hi_run = 0, sclk_cs_bad = 0;
  logic [AB-1:0] mosi_bits;
  logic [NB-1:0] cur_word;
  int            r_rise, r_fall, r_cs_low, r_hi_bad, r_lo_n, r_lo_gap;
  logic [AB-1:0] r_mosi;

  always @(negedge clk) begin
    if (bus.sclk === 1'b1 && bus.cs === 1'b1) sclk_cs_bad++;
    if (bus.cs === 1'b0 && prev_cs === 1'b1) begin
      last_cs_hi_run = cs_hi_run;
      rise_cnt = 0; fall_cnt = 0; cs_low_cnt = 0; hi_run = 0; lo_run = 0;
      hi_bad = 0; lo_n = 0; lo_gap = 0; mosi_bits = '0;
    end
    if (bus.cs === 1'b0) begin
      cs_low_cnt++;
      if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
        rise_cnt++;
        if (rise_cnt <= AB) mosi_bits = {mosi_bits[AB-2:0], bus.mosi};
        if (rise_cnt > 1) begin
          if (lo_run == DL) lo_n++;
          else if (lo_run == DL + 1) lo_gap++;
        end
        hi_run = 0;
      end
      if (bus.sclk === 1'b0 && prev_sclk === 1'b1) begin
        fall_cnt++;
        if (hi_run != DL) hi_bad++;
        lo_run = 0;
        if (fall_cnt == AB) cur_word = slave_word(mosi_bits);
        if (fall_cnt >= AB && fall_cnt < AB + NB) bus.miso = cur_word[NB-1-(fall_cnt-AB)];
        else bus.miso = 1'b1;
      end
      if (bus.sclk === 1'b1) hi_run++;
      else lo_run++;
    end else begin
      bus.miso = 1'b1;
      if (prev_cs === 1'b0) begin
        r_rise = rise_cnt; r_fall = fall_cnt; r_cs_low = cs_low_cnt; r_hi_bad = hi_bad;
        r_lo_n = lo_n; r_lo_gap = lo_gap; r_mosi = mosi_bits;
        cs_hi_run = 0;
      end
      cs_hi_run++;
    end
    prev_cs = bus.cs;
    prev_sclk = bus.sclk;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Issues one read when idle; returns start-to-valid latency, data and valid-to-idle distance.
  task automatic run_read(input logic [AB-1:0] a, output int lat, output logic [NB-1:0] d,
                          output int idle_rel, output bit ok);
    int s;
    int v;
    lat = -1; d = '0; idle_rel = -1; ok = 1'b0; v = 0;
    for (int i = 0; i < 1000 && bus.busy !== 1'b0; i++) @(negedge clk);
    bus.adr = a;
    bus.start = 1'b1;
    s = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3*T && !ok; i++) begin
      if (bus.valid === 1'b1) begin
        ok = 1'b1; v = cyc; lat = cyc - s; d = bus.dout;
      end else begin
        @(negedge clk);
      end
    end
    if (ok) begin
      for (int i = 0; i < 100 && idle_rel < 0; i++) begin
        @(negedge clk);
        if (bus.busy === 1'b0) idle_rel = cyc - v;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.cs !== 1'b1)    begin errors++; $display("FAIL reset_cs: got %b want 1", bus.cs); end
    checks++; if (bus.sclk !== 1'b0)  begin errors++; $display("FAIL reset_sclk: got %b want 0", bus.sclk); end
    checks++; if (bus.mosi !== 1'b1)  begin errors++; $display("FAIL reset_mosi: got %b want 1", bus.mosi); end
    checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    checks++; if (bus.dout !== '0)    begin errors++; $display("FAIL reset_dout: got %h want 0", bus.dout); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.cs !== 1'b1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset: got cs=%b busy=%b want cs=1 busy=0", bus.cs, bus.busy); end
    $display("txn reset: outputs checked");
  endtask

  task automatic test_fixed_reads();
    logic [AB-1:0] a;
    logic [NB-1:0] exp, d;
    int lat, idle_rel;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      a   = (i == 0) ? 8'd1 : 8'd3;
      exp = (i == 0) ? 32'hDEEDBEEF : 32'hFFFFFFFF;
      run_read(a, lat, d, idle_rel, ok);
      checks++; if (!ok || lat != T) begin errors++; $display("FAIL fixed_latency adr=%0d: got %0d want %0d", a, lat, T); end
      checks++; if (d !== exp) begin errors++; $display("FAIL fixed_dout adr=%0d: got %h want %h", a, d, exp); end
      checks++; if (idle_rel != CSI - 1) begin errors++; $display("FAIL fixed_idle adr=%0d: got %0d want %0d", a, idle_rel, CSI-1); end
      checks++; if (r_rise != AB + NB || r_fall != AB + NB)
        begin errors++; $display("FAIL fixed_edges adr=%0d: got rise=%0d fall=%0d want %0d", a, r_rise, r_fall, AB+NB); end
      checks++; if (r_hi_bad != 0 || r_lo_n != AB + NB - 2 || r_lo_gap != 1)
        begin errors++; $display("FAIL fixed_sclk_shape adr=%0d: got hibad=%0d lo=%0d gap=%0d want 0 %0d 1", a, r_hi_bad, r_lo_n, r_lo_gap, AB+NB-2); end
      checks++; if (r_cs_low != T - 1) begin errors++; $display("FAIL fixed_cs_low adr=%0d: got %0d want %0d", a, r_cs_low, T-1); end
      checks++; if (r_mosi !== a) begin errors++; $display("FAIL fixed_mosi adr=%0d: got %b want %b", a, r_mosi, a); end
      $display("txn fixed adr=%0d lat=%0d dout=%h mosi=%b", a, lat, d, r_mosi);
    end
  endtask

  task automatic test_random_reads();
    logic [AB-1:0] a;
    logic [NB-1:0] d;
    int lat, idle_rel;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      a = AB'($urandom_range(0, 255));
      run_read(a, lat, d, idle_rel, ok);
      checks++; if (!ok || lat != T) begin errors++; $display("FAIL rand_latency adr=%0d: got %0d want %0d", a, lat, T); end
      checks++; if (d !== slave_word(a)) begin errors++; $display("FAIL rand_dout adr=%0d: got %h want %h", a, d, slave_word(a)); end
      checks++; if (r_mosi !== a) begin errors++; $display("FAIL rand_mosi adr=%0d: got %b want %b", a, r_mosi, a); end
      $display("txn random adr=%0d lat=%0d dout=%h", a, lat, d);
    end
  endtask

  task automatic test_ignored_start();
    logic [AB-1:0] a, b;
    logic [NB-1:0] d;
    int nvalid, vk;
    a = AB'($urandom_range(4, 250));
    b = a ^ 8'hFF;
    nvalid = 0; vk = -1; d = '0;
    bus.adr = a;
    bus.start = 1'b1;
    for (int k = 1; k <= T + CSI + 40; k++) begin
      @(negedge clk);
      bus.start = (k == 50 || k == 200);
      bus.adr   = (k == 50 || k == 200) ? b : a;
      if (k == 50 || k == 200) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ignored_busy k=%0d: got %b want 1", k, bus.busy); end
      end
      if (bus.valid === 1'b1) begin nvalid++; vk = k; d = bus.dout; end
    end
    bus.start = 1'b0;
    checks++; if (nvalid != 1) begin errors++; $display("FAIL ignored_count: got %0d want 1", nvalid); end
    checks++; if (vk != T) begin errors++; $display("FAIL ignored_latency: got %0d want %0d", vk, T); end
    checks++; if (d !== slave_word(a)) begin errors++; $display("FAIL ignored_dout: got %h want %h", d, slave_word(a)); end
    checks++; if (r_mosi !== a) begin errors++; $display("FAIL ignored_mosi: got %b want %b", r_mosi, a); end
    $display("txn ignored-start adr=%0d valids=%0d dout=%h", a, nvalid, d);
  endtask

  task automatic test_midreset();
    logic [AB-1:0] a;
    logic [NB-1:0] d;
    int nvalid, lat, idle_rel;
    bit ok;
    a = AB'($urandom_range(0, 255));
    bus.adr = a;
    bus.start = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.cs !== 1'b1)    begin errors++; $display("FAIL midrst_cs: got %b want 1", bus.cs); end
    checks++; if (bus.sclk !== 1'b0)  begin errors++; $display("FAIL midrst_sclk: got %b want 0", bus.sclk); end
    checks++; if (bus.mosi !== 1'b1)  begin errors++; $display("FAIL midrst_mosi: got %b want 1", bus.mosi); end
    checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.dout !== '0)    begin errors++; $display("FAIL midrst_dout: got %h want 0", bus.dout); end
    rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < T + 50; k++) begin
      if (bus.valid === 1'b1) nvalid++;
      @(negedge clk);
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL midrst_novalid: got %0d want 0", nvalid); end
    a = AB'($urandom_range(0, 255));
    run_read(a, lat, d, idle_rel, ok);
    checks++; if (!ok || lat != T || d !== slave_word(a))
      begin errors++; $display("FAIL midrst_reread adr=%0d: got lat=%0d dout=%h want lat=%0d dout=%h", a, lat, d, T, slave_word(a)); end
    $display("txn mid-reset then adr=%0d dout=%h", a, d);
  endtask

  task automatic test_back_to_back();
    int s, nv;
    int v[2];
    logic [NB-1:0] dv[2];
    nv = 0; v[0] = -1; v[1] = -1; dv[0] = '0; dv[1] = '0;
    for (int i = 0; i < 1000 && bus.busy !== 1'b0; i++) @(negedge clk);
    bus.adr = 8'd1;
    bus.start = 1'b1;
    s = cyc;
    for (int k = 1; k <= 2*T + CSI + 40 && nv < 2; k++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin v[nv] = cyc; dv[nv] = bus.dout; nv++; end
    end
    bus.start = 1'b0;
    for (int i = 0; i < 100 && bus.busy !== 1'b0; i++) @(negedge clk);
    checks++; if (nv != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", nv); end
    checks++; if (v[0] - s != T) begin errors++; $display("FAIL b2b_first: got %0d want %0d", v[0] - s, T); end
    checks++; if (v[1] - v[0] != T + CSI - 1) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", v[1] - v[0], T+CSI-1); end
    checks++; if (dv[0] !== 32'hDEEDBEEF || dv[1] !== 32'hDEEDBEEF)
      begin errors++; $display("FAIL b2b_dout: got %h %h want deedbeef", dv[0], dv[1]); end
    checks++; if (last_cs_hi_run != CSI) begin errors++; $display("FAIL b2b_cs_high: got %0d want %0d", last_cs_hi_run, CSI); end
    checks++; if (r_rise != AB + NB) begin errors++; $display("FAIL b2b_edges: got %0d want %0d", r_rise, AB+NB); end
    $display("txn back-to-back spacing=%0d cs_high=%0d", v[1] - v[0], last_cs_hi_run);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.adr = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_fixed_reads();
    test_random_reads();
    test_ignored_start();
    test_midreset();
    test_back_to_back();
    checks++; if (sclk_cs_bad != 0) begin errors++; $display("FAIL sclk_while_cs_high: got %0d want 0", sclk_cs_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
